axil_bram_ctrl: RTL and testbench

//  AXI4-Lite slave that turns single-beat register reads/writes into port-A

---
 rtl/axil_bram_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_axil_bram_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_bram_ctrl.sv
// AXI4-Lite slave bridging single-beat register accesses onto BRAM port A.
// One transaction in flight; absorbs the RAM's 1- or 2-cycle read latency.
module axil_bram_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = 1,
    localparam int BAW         = $clog2(RAM_DEPTH),
    localparam int STRB_W      = DATA_WIDTH / 8
) (
    input  logic                  clka,
    input  logic                  rstb,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_W-1:0]     s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [BAW-1:0]        bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic                  bram_regce,
    input  logic [DATA_WIDTH-1:0] bram_dout
);
    localparam int OFFS = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE, W_ACC, W_MEM, W_RESP, R_ACC, R_MEM, R_WAIT, R_RESP
    } state_t;

    state_t state_reg, state_next;
    logic                  wr_first_reg, wr_first_next;
    logic                  err_reg, err_next;
    logic [1:0]            cnt_reg, cnt_next;
    logic                  awready_reg, awready_next;
    logic                  wready_reg, wready_next;
    logic                  arready_reg, arready_next;
    logic                  bvalid_reg, bvalid_next;
    logic [1:0]            bresp_reg, bresp_next;
    logic                  rvalid_reg, rvalid_next;
    logic [1:0]            rresp_reg, rresp_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic [BAW-1:0]        addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] din_reg, din_next;
    logic                  en_reg, en_next;
    logic                  we_reg, we_next;
    logic                  regce_reg, regce_next;

    logic wr_elig, rd_elig, wr_in_range, rd_in_range;
    logic unused_addr_bits;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a[ADDR_WIDTH-1:OFFS]) < RAM_DEPTH;
    endfunction

    assign wr_elig     = s_axil_awvalid && s_axil_wvalid;
    assign rd_elig     = s_axil_arvalid;
    assign wr_in_range = in_range(s_axil_awaddr);
    assign rd_in_range = in_range(s_axil_araddr);
    assign unused_addr_bits = ^{s_axil_awaddr[OFFS-1:0], s_axil_araddr[OFFS-1:0]};

    always_comb begin
        state_next    = state_reg;
        wr_first_next = wr_first_reg;
        err_next      = err_reg;
        cnt_next      = cnt_reg;
        awready_next  = 1'b0;
        wready_next   = 1'b0;
        arready_next  = 1'b0;
        bvalid_next   = 1'b0;
        rvalid_next   = 1'b0;
        en_next       = 1'b0;
        we_next       = 1'b0;
        regce_next    = 1'b0;
        bresp_next    = bresp_reg;
        rresp_next    = rresp_reg;
        rdata_next    = rdata_reg;
        addr_next     = addr_reg;
        din_next      = din_reg;
        case (state_reg)
            IDLE: begin
                // Pointer only moves when both sides competed for the grant
                if (wr_elig && (!rd_elig || wr_first_reg)) begin
                    state_next   = W_ACC;
                    awready_next = 1'b1;
                    wready_next  = 1'b1;
                    if (rd_elig) wr_first_next = 1'b0;
                end else if (rd_elig) begin
                    state_next   = R_ACC;
                    arready_next = 1'b1;
                    if (wr_elig) wr_first_next = 1'b1;
                end
            end
            W_ACC: begin
                state_next = W_MEM;
                en_next    = wr_in_range;
                we_next    = wr_in_range && (&s_axil_wstrb);
                err_next   = !(wr_in_range && (&s_axil_wstrb));
                if (wr_in_range) begin
                    addr_next = s_axil_awaddr[OFFS +: BAW];
                    din_next  = s_axil_wdata;
                end
            end
            W_MEM: begin
                state_next  = W_RESP;
                bvalid_next = 1'b1;
                bresp_next  = err_reg ? RESP_SLVERR : RESP_OKAY;
            end
            W_RESP: begin
                if (s_axil_bready) state_next  = IDLE;
                else               bvalid_next = 1'b1;
            end
            R_ACC: begin
                state_next = R_MEM;
                en_next    = rd_in_range;
                err_next   = !rd_in_range;
                if (rd_in_range) addr_next = s_axil_araddr[OFFS +: BAW];
            end
            R_MEM: begin
                state_next = R_WAIT;
                regce_next = 1'b1;
                cnt_next   = 2'(READ_LATENCY - 1);
            end
            R_WAIT: begin
                if (cnt_reg == 2'd0) begin
                    state_next  = R_RESP;
                    rvalid_next = 1'b1;
                    rdata_next  = err_reg ? '0 : bram_dout;
                    rresp_next  = err_reg ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    cnt_next   = cnt_reg - 2'd1;
                    regce_next = 1'b1;
                end
            end
            R_RESP: begin
                if (s_axil_rready) state_next  = IDLE;
                else               rvalid_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            state_reg    <= IDLE;
            wr_first_reg <= 1'b1;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            arready_reg  <= 1'b0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= '0;
            rvalid_reg   <= 1'b0;
            rresp_reg    <= '0;
            rdata_reg    <= '0;
            addr_reg     <= '0;
            din_reg      <= '0;
            en_reg       <= 1'b0;
            we_reg       <= 1'b0;
            regce_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_first_reg <= wr_first_next;
            err_reg      <= err_next;
            cnt_reg      <= cnt_next;
            awready_reg  <= awready_next;
            wready_reg   <= wready_next;
            arready_reg  <= arready_next;
            bvalid_reg   <= bvalid_next;
            bresp_reg    <= bresp_next;
            rvalid_reg   <= rvalid_next;
            rresp_reg    <= rresp_next;
            rdata_reg    <= rdata_next;
            addr_reg     <= addr_next;
            din_reg      <= din_next;
            en_reg       <= en_next;
            we_reg       <= we_next;
            regce_reg    <= regce_next;
        end
    end

    assign s_axil_awready = awready_reg;
    assign s_axil_wready  = wready_reg;
    assign s_axil_arready = arready_reg;
    assign s_axil_bvalid  = bvalid_reg;
    assign s_axil_bresp   = bresp_reg;
    assign s_axil_rvalid  = rvalid_reg;
    assign s_axil_rresp   = rresp_reg;
    assign s_axil_rdata   = rdata_reg;
    assign bram_addr      = addr_reg;
    assign bram_din       = din_reg;
    assign bram_en        = en_reg;
    assign bram_we        = we_reg;
    assign bram_regce     = regce_reg;
endmodule

// File: tb/tb_axil_bram_ctrl.sv
// Directed bench for axil_bram_ctrl: vector table for single accesses plus
// hand sequences for contention, backpressure and mid-read reset.
module tb_axil_bram_ctrl;
    localparam int RL = 1;

    logic        clka = 1'b0;
    logic        rstb = 1'b1;
    logic [12:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, bram_din, bram_dout;
    logic [9:0]  bram_addr;
    logic        bram_en, bram_we, bram_regce;

    int pass_cnt = 0;
    int total_cnt = 0;
    int overlap_cnt = 0;

    always #5 clka = ~clka;

    axil_bram_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(13), .RAM_DEPTH(1024), .READ_LATENCY(RL)
    ) dut (
        .clka(clka), .rstb(rstb),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(wready), .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
        .s_axil_bready(bready), .s_axil_araddr(araddr), .s_axil_arvalid(arvalid),
        .s_axil_arready(arready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_en(bram_en),
        .bram_we(bram_we), .bram_regce(bram_regce), .bram_dout(bram_dout)
    );

    // Port-A RAM model: read-first, optional output register for latency 2
    logic [31:0] mem [1024];
    logic [31:0] q1 = '0, q2 = '0;
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
    always @(posedge clka) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            q1 <= mem[bram_addr];
        end
        if (bram_regce) q2 <= q1;
    end
    assign bram_dout = (RL == 1) ? q1 : q2;

    always @(negedge clka) if (!rstb && bvalid && rvalid) overlap_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {awready, wready, arready, bvalid, bresp, rvalid, rresp,
                             bram_en, bram_we, bram_regce}, 0);
        chk({tag, "_data"}, {rdata, bram_din}, 0);
        chk({tag, "_addr"}, bram_addr, 0);
    endtask

    // which: 0 awready, 1 arready, 2 bvalid, 3 rvalid
    task automatic wait_for(input int which, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clka); #1;
            if ((which == 0 && awready) || (which == 1 && arready) ||
                (which == 2 && bvalid) || (which == 3 && rvalid)) begin
                ok = 1'b1;
                break;
            end
        end
        chk({"wait_", name}, ok, 1);
    endtask

    task automatic do_txn(input bit wr, input logic [12:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output logic [31:0] rd, output int acc_c, output int en_c,
                          output int we_c, output int resp_c, output logic [9:0] en_a);
        bit drop = 1'b0;
        acc_c = -1; en_c = -1; we_c = -1; resp_c = -1;
        resp = 2'b11; rd = 32'hFFFF_FFFF; en_a = '0;
        if (wr) begin
            awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = addr; arvalid = 1'b1;
        end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clka); #1;
            if (drop) begin awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; drop = 1'b0; end
            if ((wr && awready && wready) || (!wr && arready)) begin
                if (acc_c < 0) acc_c = i;
                drop = 1'b1;
            end
            if (bram_en && en_c < 0) begin en_c = i; en_a = bram_addr; end
            if (bram_we && we_c < 0) we_c = i;
            if ((wr && bvalid) || (!wr && rvalid)) begin
                resp_c = i; resp = wr ? bresp : rresp; rd = rdata;
                break;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clka); #1;
    endtask

    task automatic contend(input logic [12:0] a, input logic [31:0] d,
                           output int first_wr, output logic [31:0] rd);
        bit aw_drop = 1'b0, ar_drop = 1'b0, got_b = 1'b0, got_r = 1'b0;
        first_wr = -1; rd = 32'hFFFF_FFFF;
        awaddr = a; araddr = a; wdata = d; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clka); #1;
            if (aw_drop) begin awvalid = 1'b0; wvalid = 1'b0; aw_drop = 1'b0; end
            if (ar_drop) begin arvalid = 1'b0; ar_drop = 1'b0; end
            if (awready) begin aw_drop = 1'b1; if (first_wr < 0) first_wr = 1; end
            if (arready) begin ar_drop = 1'b1; if (first_wr < 0) first_wr = 0; end
            if (bvalid) got_b = 1'b1;
            if (rvalid) begin got_r = 1'b1; rd = rdata; end
            if (got_b && got_r) break;
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clka); #1;
    endtask

    typedef struct {
        bit          wr;
        logic [12:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          en_c;   // -1 never, -2 not checked
        int          we_c;
        int          resp_c;
        logic [9:0]  en_a;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [9:0]  en_a;
        int          acc_c, en_c, we_c, resp_c, first_wr, viol;
        logic [1:0]  hold_resp;

        vecs[0]  = '{1, 13'h004,  32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        2, 2,  3,      10'd1};
        vecs[1]  = '{0, 13'h004,  32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 2, -1, 3 + RL, 10'd1};
        vecs[2]  = '{1, 13'h008,  32'h12345678, 4'h3, 2'b10, 32'h0,        -2, -1, 3,     10'd0};
        vecs[3]  = '{0, 13'h008,  32'h0,        4'h0, 2'b00, 32'hA5000002, 2, -1, 3 + RL, 10'd2};
        vecs[4]  = '{1, 13'h1000, 32'h11111111, 4'hF, 2'b10, 32'h0,        -1, -1, 3,     10'd0};
        vecs[5]  = '{0, 13'h1000, 32'h0,        4'h0, 2'b10, 32'h0,        -1, -1, 3 + RL, 10'd0};
        vecs[6]  = '{1, 13'h007,  32'hCAFEF00D, 4'hF, 2'b00, 32'h0,        2, 2,  3,      10'd1};
        vecs[7]  = '{0, 13'h005,  32'h0,        4'h0, 2'b00, 32'hCAFEF00D, 2, -1, 3 + RL, 10'd1};
        vecs[8]  = '{1, 13'hFFC,  32'h0BADC0DE, 4'hF, 2'b00, 32'h0,        2, 2,  3,      10'd1023};
        vecs[9]  = '{0, 13'hFFE,  32'h0,        4'h0, 2'b00, 32'h0BADC0DE, 2, -1, 3 + RL, 10'd1023};
        vecs[10] = '{0, 13'h800,  32'h0,        4'h0, 2'b00, 32'hA5000200, 2, -1, 3 + RL, 10'd512};

        repeat (3) @(posedge clka);
        #1 rstb = 1'b0;
        check_all_zero("reset");

        foreach (vecs[k]) begin
            do_txn(vecs[k].wr, vecs[k].addr, vecs[k].data, vecs[k].strb,
                   resp, rd, acc_c, en_c, we_c, resp_c, en_a);
            $display("txn %0d %s addr=0x%h resp=%b rdata=0x%h resp_cycle=%0d",
                     k, vecs[k].wr ? "WR" : "RD", vecs[k].addr, resp, rd, resp_c);
            chk($sformatf("v%0d_resp", k), resp, vecs[k].resp);
            chk($sformatf("v%0d_acc_cycle", k), acc_c, 1);
            chk($sformatf("v%0d_resp_cycle", k), resp_c, vecs[k].resp_c);
            chk($sformatf("v%0d_we_cycle", k), we_c, vecs[k].we_c);
            if (vecs[k].en_c != -2) chk($sformatf("v%0d_en_cycle", k), en_c, vecs[k].en_c);
            if (vecs[k].en_c >= 0)  chk($sformatf("v%0d_en_addr", k), en_a, vecs[k].en_a);
            if (!vecs[k].wr)        chk($sformatf("v%0d_rdata", k), rd, vecs[k].rdata);
        end

        // Reset pulse while the read sits in R_WAIT
        araddr = 13'h004; arvalid = 1'b1;
        wait_for(1, "rst_arready");
        @(posedge clka); #1 arvalid = 1'b0;
        @(posedge clka); #1;
        chk("rst_regce_in_wait", bram_regce, 1);
        rstb = 1'b1;
        @(posedge clka); #1 rstb = 1'b0;
        check_all_zero("midrst");
        viol = 0;
        repeat (8) begin @(posedge clka); #1; if (rvalid) viol++; end
        chk("midrst_no_rvalid", viol, 0);
        do_txn(1, 13'h00C, 32'h77778888, 4'hF, resp, rd, acc_c, en_c, we_c, resp_c, en_a);
        $display("txn post-reset WR addr=0x00c resp=%b resp_cycle=%0d", resp, resp_c);
        chk("postrst_wr_resp", resp, 2'b00);
        chk("postrst_wr_we", we_c, 2);
        do_txn(0, 13'h00C, 32'h0, 4'h0, resp, rd, acc_c, en_c, we_c, resp_c, en_a);
        $display("txn post-reset RD addr=0x00c resp=%b rdata=0x%h", resp, rd);
        chk("postrst_rd_data", rd, 32'h77778888);
        chk("postrst_rd_cycle", resp_c, 3 + RL);

        // Round-robin after reset: write first, then read first next time
        contend(13'h010, 32'h0C0FFEE0, first_wr, rd);
        $display("txn contend#1 first=%s rdata=0x%h", first_wr == 1 ? "WR" : "RD", rd);
        chk("rr1_first_is_write", first_wr, 1);
        chk("rr1_rdata_new", rd, 32'h0C0FFEE0);
        contend(13'h014, 32'h22222222, first_wr, rd);
        $display("txn contend#2 first=%s rdata=0x%h", first_wr == 1 ? "WR" : "RD", rd);
        chk("rr2_first_is_read", first_wr, 0);
        chk("rr2_rdata_old", rd, 32'hA5000005);

        // Backpressure on B then R; a pending read must not be accepted early
        bready = 1'b0; rready = 1'b0;
        awaddr = 13'h018; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_for(0, "bp_awready");
        @(posedge clka); #1;
        awvalid = 1'b0; wvalid = 1'b0; araddr = 13'h018; arvalid = 1'b1;
        wait_for(2, "bp_bvalid");
        hold_resp = bresp;
        chk("bp_bresp", hold_resp, 2'b00);
        viol = 0;
        repeat (10) begin
            @(posedge clka); #1;
            if (!bvalid || bresp !== hold_resp || awready || wready || arready || bram_en || rvalid)
                viol++;
        end
        chk("bp_write_hold_viol", viol, 0);
        bready = 1'b1;
        wait_for(1, "bp_arready");
        @(posedge clka); #1 arvalid = 1'b0;
        wait_for(3, "bp_rvalid");
        viol = 0;
        repeat (10) begin
            @(posedge clka); #1;
            if (!rvalid || rdata !== 32'h5A5A5A5A || rresp !== 2'b00 ||
                awready || wready || arready || bram_en || bvalid)
                viol++;
        end
        chk("bp_read_hold_viol", viol, 0);
        $display("txn backpressure RD addr=0x018 rdata=0x%h", rdata);
        rready = 1'b1;
        @(posedge clka); #1;
        chk("bp_rvalid_drop", rvalid, 0);

        chk("bvalid_rvalid_overlap", overlap_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
